// File: rtl/sap_bus_arbiter.sv
// Registered SAP-1 bus arbiter/multiplexer: fixed-priority or round-robin source
// selection, registered bus value and grant, sticky conflict flag with saturating count.
module sap_bus_arbiter #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned N_SRC = 5,
  parameter int unsigned MODE  = 0,
  parameter int unsigned HOLD  = 1,
  parameter int unsigned CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_SRC-1:0]       en_req,
  input  logic [N_SRC*WIDTH-1:0] bus_in,
  input  logic                   conflict_clr,
  output logic [WIDTH-1:0]       bus_out,
  output logic                   bus_valid,
  output logic [N_SRC-1:0]       grant,
  output logic                   conflict,
  output logic [CNT_W-1:0]       conflict_cnt
);

  localparam int unsigned      PW      = $clog2(N_SRC);
  localparam logic [PW-1:0]    PtrRst  = PW'(N_SRC - 1);
  localparam logic [CNT_W-1:0] CntMax  = '1;

  logic [WIDTH-1:0] src [N_SRC];

  for (genvar gi = 0; gi < N_SRC; gi++) begin : g_src
    assign src[gi] = bus_in[gi*WIDTH +: WIDTH];
  end

  logic [PW-1:0]    ptr_q, ptr_d;
  logic [PW-1:0]    gnt_idx, cand;
  logic             found, multi;
  logic [WIDTH-1:0] bus_out_q, bus_out_d;
  logic             bus_valid_q, bus_valid_d;
  logic [N_SRC-1:0] grant_q, grant_d;
  logic             conflict_q, conflict_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Grant selection: lowest index, or first set bit after the last grant (wrapping).
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    if (MODE == 0) begin
      for (int unsigned i = 0; i < N_SRC; i++) begin
        if (!found && en_req[PW'(i)]) begin
          found   = 1'b1;
          gnt_idx = PW'(i);
        end
      end
    end else begin
      for (int unsigned i = 1; i <= N_SRC; i++) begin
        cand = PW'((32'(ptr_q) + i) % N_SRC);
        if (!found && en_req[cand]) begin
          found   = 1'b1;
          gnt_idx = cand;
        end
      end
    end
  end

  assign multi = ($countones(en_req) > 1);

  always_comb begin
    grant_d     = '0;
    bus_valid_d = found;
    bus_out_d   = bus_out_q;
    ptr_d       = ptr_q;
    conflict_d  = conflict_q;
    cnt_d       = cnt_q;
    if (found) begin
      grant_d[gnt_idx] = 1'b1;
      bus_out_d        = src[gnt_idx];
      if (MODE != 0) ptr_d = gnt_idx;
    end else if (HOLD == 0) begin
      bus_out_d = '0;
    end
    // A conflict in the same cycle as a clear wins and restarts the count at one.
    if (multi) begin
      conflict_d = 1'b1;
      if (conflict_clr)         cnt_d = CNT_W'(1);
      else if (cnt_q != CntMax) cnt_d = cnt_q + CNT_W'(1);
    end else if (conflict_clr) begin
      conflict_d = 1'b0;
      cnt_d      = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_out_q   <= '0;
      bus_valid_q <= 1'b0;
      grant_q     <= '0;
      conflict_q  <= 1'b0;
      cnt_q       <= '0;
      ptr_q       <= PtrRst;
    end else begin
      bus_out_q   <= bus_out_d;
      bus_valid_q <= bus_valid_d;
      grant_q     <= grant_d;
      conflict_q  <= conflict_d;
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
    end
  end

  assign bus_out      = bus_out_q;
  assign bus_valid    = bus_valid_q;
  assign grant        = grant_q;
  assign conflict     = conflict_q;
  assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_sap_bus_arbiter.sv
// Directed self-checking bench for sap_bus_arbiter across several parameter sets.
module tb_sap_bus_arbiter;

  logic        clk, rst, clr;
  logic [4:0]  en_req;
  logic [39:0] bus_in;
  logic [2:0]  en_req3;
  logic [47:0] bus_in3;

  logic [7:0]  bo0, bo1, bo2;
  logic        bv0, bv1, bv2;
  logic [4:0]  gr0, gr1, gr2;
  logic        cf0, cf1, cf2;
  logic [7:0]  cc0, cc1, cc2;
  logic [15:0] bo3;
  logic        bv3, cf3;
  logic [2:0]  gr3;
  logic [7:0]  cc3;

  int n_vec = 0;
  int n_bad = 0;

  // Fixed priority, hold
  sap_bus_arbiter #(.WIDTH(8), .N_SRC(5), .MODE(0), .HOLD(1), .CNT_W(8)) u_fix (
    .clk(clk), .rst(rst), .en_req(en_req), .bus_in(bus_in), .conflict_clr(clr),
    .bus_out(bo0), .bus_valid(bv0), .grant(gr0), .conflict(cf0), .conflict_cnt(cc0));
  // Fixed priority, clear on idle
  sap_bus_arbiter #(.WIDTH(8), .N_SRC(5), .MODE(0), .HOLD(0), .CNT_W(8)) u_nohold (
    .clk(clk), .rst(rst), .en_req(en_req), .bus_in(bus_in), .conflict_clr(clr),
    .bus_out(bo1), .bus_valid(bv1), .grant(gr1), .conflict(cf1), .conflict_cnt(cc1));
  // Round-robin
  sap_bus_arbiter #(.WIDTH(8), .N_SRC(5), .MODE(1), .HOLD(1), .CNT_W(8)) u_rr (
    .clk(clk), .rst(rst), .en_req(en_req), .bus_in(bus_in), .conflict_clr(clr),
    .bus_out(bo2), .bus_valid(bv2), .grant(gr2), .conflict(cf2), .conflict_cnt(cc2));
  // Wide bus, three sources
  sap_bus_arbiter #(.WIDTH(16), .N_SRC(3), .MODE(0), .HOLD(1), .CNT_W(8)) u_wide (
    .clk(clk), .rst(rst), .en_req(en_req3), .bus_in(bus_in3), .conflict_clr(clr),
    .bus_out(bo3), .bus_valid(bv3), .grant(gr3), .conflict(cf3), .conflict_cnt(cc3));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    en_req  = '0;
    en_req3 = '0;
    clr     = 1'b0;
    rst     = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    en_req  = '0;
    en_req3 = '0;
    clr     = 1'b0;
    bus_in  = '0;
    bus_in3 = '0;
    rst     = 1'b1;
    #2;
    if ({bo0, bv0, gr0, cf0, cc0} !== 23'd0) begin
      $display("FAIL reset_fix: got %h required 0", {bo0, bv0, gr0, cf0, cc0}); n_bad++;
    end
    n_vec++;
    if ({bo2, bv2, gr2, cf2, cc2} !== 23'd0) begin
      $display("FAIL reset_rr: got %h required 0", {bo2, bv2, gr2, cf2, cc2}); n_bad++;
    end
    n_vec++;
    if ({bo3, bv3, gr3, cf3, cc3} !== 29'd0) begin
      $display("FAIL reset_wide: got %h required 0", {bo3, bv3, gr3, cf3, cc3}); n_bad++;
    end
    n_vec++;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_single_grant();
    do_reset();
    bus_in[7:0] = 8'hA5;
    en_req      = 5'b00001;
    tick();
    if (bo0 !== 8'hA5 || gr0 !== 5'b00001 || bv0 !== 1'b1) begin
      $display("FAIL single_edge1: got bus=%h gnt=%b vld=%b required a5 00001 1", bo0, gr0, bv0);
      n_bad++;
    end
    n_vec++;
    en_req      = '0;
    bus_in[7:0] = 8'hFF;  // changed after the edge; must not reach the bus
    tick();
    if (bo0 !== 8'hA5 || gr0 !== 5'b00000 || bv0 !== 1'b0) begin
      $display("FAIL single_hold: got bus=%h gnt=%b vld=%b required a5 00000 0", bo0, gr0, bv0);
      n_bad++;
    end
    n_vec++;
    if (bo1 !== 8'h00 || bv1 !== 1'b0) begin
      $display("FAIL single_nohold: got bus=%h vld=%b required 00 0", bo1, bv1); n_bad++;
    end
    n_vec++;
    if (cf0 !== 1'b0 || cc0 !== 8'd0) begin
      $display("FAIL single_noconf: got cf=%b cnt=%0d required 0 0", cf0, cc0); n_bad++;
    end
    n_vec++;
  endtask

  task automatic test_fixed_priority();
    do_reset();
    bus_in        = '0;
    bus_in[23:16] = 8'h3C;
    bus_in[39:32] = 8'hF0;
    en_req        = 5'b10100;
    tick();
    if (bo0 !== 8'h3C || gr0 !== 5'b00100) begin
      $display("FAIL fixed_prio: got bus=%h gnt=%b required 3c 00100", bo0, gr0); n_bad++;
    end
    n_vec++;
    if (cf0 !== 1'b1 || cc0 !== 8'd1) begin
      $display("FAIL fixed_conf: got cf=%b cnt=%0d required 1 1", cf0, cc0); n_bad++;
    end
    n_vec++;
  endtask

  task automatic test_round_robin();
    logic [4:0] exp_g;
    logic [7:0] exp_b;
    do_reset();
    bus_in = 40'h55_44_33_22_11;
    en_req = 5'b11111;
    for (int k = 0; k < 10; k++) begin
      tick();
      exp_g = 5'b00001 << (k % 5);
      exp_b = 8'((k % 5 + 1) * 17);
      if (gr2 !== exp_g || bo2 !== exp_b) begin
        $display("FAIL rr_cycle%0d: got gnt=%b bus=%h required %b %h", k, gr2, bo2, exp_g, exp_b);
        n_bad++;
      end
      n_vec++;
    end
    if (cc2 !== 8'd10) begin
      $display("FAIL rr_count: got %0d required 10", cc2); n_bad++;
    end
    n_vec++;
    if (gr0 !== 5'b00001) begin
      $display("FAIL fix_all: got %b required 00001", gr0); n_bad++;
    end
    n_vec++;
    en_req = 5'b01000;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (gr2 !== 5'b01000 || bo2 !== 8'h44 || bv2 !== 1'b1) begin
        $display("FAIL rr_single%0d: got gnt=%b bus=%h required 01000 44", k, gr2, bo2);
        n_bad++;
      end
      n_vec++;
    end
  endtask

  task automatic test_saturation();
    do_reset();
    en_req = 5'b00011;
    for (int k = 0; k < 300; k++) tick();
    if (cc0 !== 8'd255 || cf0 !== 1'b1) begin
      $display("FAIL sat_count: got cnt=%0d cf=%b required 255 1", cc0, cf0); n_bad++;
    end
    n_vec++;
    clr = 1'b1;
    tick();
    if (cc0 !== 8'd1 || cf0 !== 1'b1) begin
      $display("FAIL clr_with_conf: got cnt=%0d cf=%b required 1 1", cc0, cf0); n_bad++;
    end
    n_vec++;
    en_req = 5'b00000;
    tick();
    if (cc0 !== 8'd0 || cf0 !== 1'b0) begin
      $display("FAIL clr_idle: got cnt=%0d cf=%b required 0 0", cc0, cf0); n_bad++;
    end
    n_vec++;
    clr = 1'b0;
  endtask

  task automatic test_async_reset();
    do_reset();
    bus_in = 40'h55_44_33_22_11;
    en_req = 5'b00001;
    tick();
    en_req = 5'b00010;
    tick();
    if (gr2 !== 5'b00010 || bo2 !== 8'h22) begin
      $display("FAIL areset_pre: got gnt=%b bus=%h required 00010 22", gr2, bo2); n_bad++;
    end
    n_vec++;
    #2;
    rst = 1'b1;
    #1;
    if ({bo2, bv2, gr2, cf2, cc2} !== 23'd0) begin
      $display("FAIL areset_async: got %h required 0", {bo2, bv2, gr2, cf2, cc2}); n_bad++;
    end
    n_vec++;
    #1;
    rst    = 1'b0;
    en_req = 5'b00110;
    tick();
    if (gr2 !== 5'b00010 || bo2 !== 8'h22) begin
      $display("FAIL areset_ptr: got gnt=%b bus=%h required 00010 22", gr2, bo2); n_bad++;
    end
    n_vec++;
  endtask

  task automatic test_wide();
    do_reset();
    bus_in3 = 48'hBEEF_2222_1111;
    en_req3 = 3'b100;
    tick();
    if (bo3 !== 16'hBEEF || gr3 !== 3'b100 || cf3 !== 1'b0) begin
      $display("FAIL wide_src2: got bus=%h gnt=%b cf=%b required beef 100 0", bo3, gr3, cf3);
      n_bad++;
    end
    n_vec++;
    en_req3 = 3'b011;
    tick();
    if (bo3 !== 16'h1111 || gr3 !== 3'b001 || cf3 !== 1'b1 || cc3 !== 8'd1) begin
      $display("FAIL wide_conf: got bus=%h gnt=%b cf=%b cnt=%0d required 1111 001 1 1",
               bo3, gr3, cf3, cc3);
      n_bad++;
    end
    n_vec++;
  endtask

  initial begin
    test_reset();
    test_single_grant();
    test_fixed_priority();
    test_round_robin();
    test_saturation();
    test_async_reset();
    test_wide();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
